gate_test_sequencer: RTL

GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

---
 rtl/gate_test_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer
//   Applies the four input vectors {a,b} = 00, 01, 10, 11 to a two-input gate.
//   Each vector is held for SETTLE cycles. The gate output y is compared with
//   the truth table latched at start, and the per-vector mismatches are reported.
//
// Parameters
//   SETTLE   : cycles each vector is held (1..15); y is sampled on the last one
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   start    : run request (accepted in IDLE/DONE when abort is low)
//   abort    : cancel run / clear results, returns to IDLE
//   tt[3:0]  : expected truth table, tt[{a,b}] is the expected y
//   y        : output of the gate under test
//   a, b     : operands driven to the gate under test
//   busy     : high while vectors are being applied
//   done     : run completed, held until next accepted start or abort
//   pass     : high with done when no vector mismatched
//   err_mask : bit i set if vector i mismatched
//   err_cnt  : number of mismatching vectors (0..4)
module gate_test_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] tt,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask,
    output logic [2:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] settle_cnt;
    logic [3:0] tt_lat;

    logic       mismatch;
    logic [3:0] mask_next;

    // Only meaningful on the sample cycle; the FSM ignores it otherwise.
    assign mismatch = (y != tt_lat[idx]);

    // Mask including the current sample, so pass can account for the final
    // vector in the same edge that enters DONE.
    always_comb begin
        mask_next = err_mask;
        if (mismatch) begin
            mask_next[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            settle_cnt <= 4'd0;
            tt_lat     <= 4'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_mask   <= 4'd0;
            err_cnt    <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state      <= DRIVE;
                        tt_lat     <= tt;
                        idx        <= 2'd0;
                        settle_cnt <= 4'd0;
                        {a, b}     <= 2'b00;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_mask   <= 4'd0;
                        err_cnt    <= 3'd0;
                    end
                end

                DRIVE: begin
                    if (abort) begin
                        state      <= IDLE;
                        idx        <= 2'd0;
                        settle_cnt <= 4'd0;
                        {a, b}     <= 2'b00;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_mask   <= 4'd0;
                        err_cnt    <= 3'd0;
                    end else if (settle_cnt == LAST) begin
                        // Last cycle of the hold: this is the only cycle y counts.
                        err_mask   <= mask_next;
                        settle_cnt <= 4'd0;
                        if (mismatch) begin
                            err_cnt <= err_cnt + 3'd1;
                        end
                        if (idx == 2'd3) begin
                            state  <= DONE;
                            idx    <= 2'd0;
                            {a, b} <= 2'b00;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            pass   <= (mask_next == 4'd0);
                        end else begin
                            idx    <= idx + 2'd1;
                            {a, b} <= idx + 2'd1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                DONE: begin
                    if (abort) begin
                        state    <= IDLE;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        err_mask <= 4'd0;
                        err_cnt  <= 3'd0;
                    end else if (start) begin
                        state      <= DRIVE;
                        tt_lat     <= tt;
                        idx        <= 2'd0;
                        settle_cnt <= 4'd0;
                        {a, b}     <= 2'b00;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_mask   <= 4'd0;
                        err_cnt    <= 3'd0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
